// File: rtl/switch_arbiter.sv
// rtl/switch_arbiter.sv - round-robin crossbar arbiter writing one word per grant into destination FIFOs
module switch_arbiter #(
  parameter logic SW_ADR = 1'b1,
  parameter int   AW_DEV = 2,
  parameter int   DW     = 4,
  parameter int   N_DEV  = 1 << AW_DEV
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_DEV-1:0]     rqt_i,
  input  logic [N_DEV*3-1:0]   adr_i,
  input  logic [N_DEV*DW-1:0]  dat_i,
  output logic [N_DEV-1:0]     gnt_o,
  input  logic [N_DEV-1:0]     full_i,
  output logic [N_DEV-1:0]     wen_o,
  output logic [DW+AW_DEV:0]   fifo_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT    = 2'd1,
    WRITE  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AW_DEV-1:0]   ptr_q, ptr_d;
  logic [AW_DEV-1:0]   src_q, src_d;
  logic [AW_DEV-1:0]   dst_q, dst_d;
  logic [DW-1:0]       pay_q, pay_d;
  logic [N_DEV-1:0]    gnt_q, gnt_d;
  logic [N_DEV-1:0]    wen_q, wen_d;
  logic [DW+AW_DEV:0]  fifo_q, fifo_d;

  logic [AW_DEV-1:0]   port_dst [N_DEV];
  logic [DW-1:0]       port_dat [N_DEV];
  logic [N_DEV-1:0]    elig;
  logic                win_found;
  logic [AW_DEV-1:0]   win_idx;
  logic [AW_DEV-1:0]   cand;

  // Only the low address bits route; the upper bit of each field is ignored.
  logic unused_adr_hi;
  assign unused_adr_hi = ^adr_i;

  // Per-port unpacking and eligibility: a requester counts only if its target FIFO has room.
  for (genvar g = 0; g < N_DEV; g++) begin : g_port
    assign port_dst[g] = adr_i[3*g +: AW_DEV];
    assign port_dat[g] = dat_i[DW*g +: DW];
    assign elig[g]     = rqt_i[g] & ~full_i[port_dst[g]];
  end

  // Round-robin pick: first eligible port scanning upward from ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int k = 0; k < N_DEV; k++) begin
      cand = ptr_q + AW_DEV'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one arbitration slot every four cycles once a winner exists.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = GNT;
      GNT:     state_d = WRITE;
      WRITE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture winner in IDLE, format the FIFO word during GNT.
  always_comb begin
    ptr_d  = ptr_q;
    src_d  = src_q;
    dst_d  = dst_q;
    pay_d  = pay_q;
    gnt_d  = '0;
    wen_d  = '0;
    fifo_d = fifo_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          src_d          = win_idx;
          dst_d          = port_dst[win_idx];
          pay_d          = port_dat[win_idx];
        end
      end
      GNT: begin
        wen_d[dst_q] = 1'b1;
        fifo_d       = {SW_ADR, src_q, pay_q};
        ptr_d        = src_q + AW_DEV'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers; reset drops any pending write and restarts priority at port 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      pay_q  <= '0;
      gnt_q  <= '0;
      wen_q  <= '0;
      fifo_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      src_q  <= src_d;
      dst_q  <= dst_d;
      pay_q  <= pay_d;
      gnt_q  <= gnt_d;
      wen_q  <= wen_d;
      fifo_q <= fifo_d;
    end
  end

  // Outputs: registered grant/write strobes and a state-derived busy flag.
  always_comb begin
    gnt_o  = gnt_q;
    wen_o  = wen_q;
    fifo_o = fifo_q;
    busy_o = (state_q != IDLE);
  end

endmodule

// File: tb/tb_switch_arbiter.sv
// tb/tb_switch_arbiter.sv - directed scoreboard bench for switch_arbiter
module tb_switch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rqt;
  logic [11:0] adr;
  logic [15:0] dat;
  logic [3:0]  gnt;
  logic [3:0]  full;
  logic [3:0]  full_force;
  logic [3:0]  full_occ;
  logic [3:0]  wen;
  logic [6:0]  fifo;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int occ [4];
  logic track = 1'b0;

  typedef struct packed {
    logic [3:0] wen;
    logic [6:0] word;
  } wr_t;
  wr_t exp_q [$];

  switch_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .rqt_i (rqt),
    .adr_i (adr),
    .dat_i (dat),
    .gnt_o (gnt),
    .full_i(full),
    .wen_o (wen),
    .fifo_o(fifo),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Destination FIFO occupancy model, depth 4, active only while tracking.
  always_comb begin
    full_occ = '0;
    for (int d = 0; d < 4; d++) full_occ[d] = track && (occ[d] >= 4);
  end
  assign full = full_force | full_occ;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [1:0] d, input logic [3:0] v);
    adr[3*p +: 3] = {1'b1, d};
    dat[4*p +: 4] = v;
  endtask

  function automatic logic [6:0] word(input int src, input logic [3:0] v);
    logic [1:0] s;
    s = src[1:0];
    return {1'b1, s, v};
  endfunction

  function automatic wr_t mk(input logic [3:0] w, input logic [6:0] wd);
    wr_t e;
    e.wen  = w;
    e.word = wd;
    return e;
  endfunction

  task automatic wait_grant(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (gnt !== 4'b0) break;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Write monitor: every FIFO write must match the next scoreboard entry.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (wen !== 4'b0) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write observed wen=0x%0h fifo=0x%0h expected no write", wen, fifo);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_wen", wen, e.wen);
        check("write_word", fifo, e.word);
      end
      for (int d = 0; d < 4; d++) begin
        if (wen[d] && track) begin
          check("write_not_full", (occ[d] >= 4), 0);
          occ[d]++;
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 4; d++) occ[d] = 0;
    rst = 1'b1; rqt = '0; adr = '0; dat = '0; full_force = '0;
    drain(2);
    check("reset_gnt", gnt, 0);
    check("reset_wen", wen, 0);
    check("reset_fifo", fifo, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single request: port 1 -> dest 0, data A
    set_port(1, 2'd0, 4'hA);
    rqt = 4'b0010;
    exp_q.push_back(mk(4'b0001, 7'b1_01_1010));
    tick();
    check("single_gnt", gnt, 4'b0010);
    check("single_busy", busy, 1);
    rqt = 4'b0000;
    tick();
    check("single_gnt_drop", gnt, 0);
    check("single_wen", wen, 4'b0001);
    check("single_fifo", fifo, 7'b1_01_1010);
    tick();
    check("single_wen_drop", wen, 0);
    check("single_busy_settle", busy, 1);
    tick();
    check("single_idle", busy, 0);

    // Round-robin among ports 0, 2, 3 from ptr 0
    rst = 1'b1; tick(); rst = 1'b0;
    set_port(0, 2'd1, 4'h5);
    set_port(2, 2'd3, 4'hC);
    set_port(3, 2'd2, 4'h7);
    exp_q.push_back(mk(4'b0010, word(0, 4'h5)));
    exp_q.push_back(mk(4'b1000, word(2, 4'hC)));
    exp_q.push_back(mk(4'b0100, word(3, 4'h7)));
    exp_q.push_back(mk(4'b0010, word(0, 4'h5)));
    rqt = 4'b1101;
    wait_grant(cyc);
    check("rr_gnt0", gnt, 4'b0001);
    check("rr_lat0", cyc, 1);
    wait_grant(cyc);
    check("rr_gnt2", gnt, 4'b0100);
    check("rr_gap2", cyc, 4);
    wait_grant(cyc);
    check("rr_gnt3", gnt, 4'b1000);
    check("rr_gap3", cyc, 4);
    wait_grant(cyc);
    check("rr_gnt0b", gnt, 4'b0001);
    check("rr_gap0b", cyc, 4);
    rqt = 4'b0000;
    drain(4);

    // Full skip: port 0 destination full, port 1 wins, then port 0
    rst = 1'b1; tick(); rst = 1'b0;
    set_port(0, 2'd2, 4'h3);
    set_port(1, 2'd3, 4'hE);
    full_force = 4'b0100;
    exp_q.push_back(mk(4'b1000, word(1, 4'hE)));
    rqt = 4'b0011;
    wait_grant(cyc);
    check("skip_gnt1", gnt, 4'b0010);
    rqt = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("skip_hold", gnt, 0);
    end
    full_force = 4'b0000;
    exp_q.push_back(mk(4'b0100, word(0, 4'h3)));
    wait_grant(cyc);
    check("skip_gnt0", gnt, 4'b0001);
    rqt = 4'b0000;
    drain(4);
    set_port(1, 2'd0, 4'h1);
    set_port(2, 2'd1, 4'h2);
    exp_q.push_back(mk(4'b0001, word(1, 4'h1)));
    exp_q.push_back(mk(4'b0010, word(2, 4'h2)));
    rqt = 4'b0110;
    wait_grant(cyc);
    check("skip_ptr_gnt1", gnt, 4'b0010);
    rqt = 4'b0100;
    wait_grant(cyc);
    check("skip_ptr_gnt2", gnt, 4'b0100);
    rqt = 4'b0000;
    drain(4);

    // Fill boundary: dest 0 holds 3 of 4, ports 0 and 2 both target it
    track = 1'b1;
    occ[0] = 3;
    set_port(0, 2'd0, 4'h8);
    set_port(2, 2'd0, 4'h4);
    exp_q.push_back(mk(4'b0001, word(0, 4'h8)));
    rqt = 4'b0101;
    wait_grant(cyc);
    check("fill_gnt0", gnt, 4'b0001);
    rqt = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("fill_hold", gnt, 0);
    end
    occ[0] = occ[0] - 1;
    exp_q.push_back(mk(4'b0001, word(2, 4'h4)));
    wait_grant(cyc);
    check("fill_gnt2", gnt, 4'b0100);
    rqt = 4'b0000;
    drain(4);
    track = 1'b0;

    // Mid-operation reset during GNT
    set_port(0, 2'd1, 4'h6);
    set_port(3, 2'd2, 4'hF);
    rqt = 4'b1001;
    tick();
    check("rst_pre_gnt", gnt, 4'b1000);
    rst = 1'b1;
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_wen", wen, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    exp_q.push_back(mk(4'b0010, word(0, 4'h6)));
    wait_grant(cyc);
    check("rst_ptr_gnt0", gnt, 4'b0001);
    check("rst_ptr_lat", cyc, 1);
    rqt = 4'b0000;
    drain(4);

    // Request withdrawn after capture
    set_port(2, 2'd1, 4'h9);
    exp_q.push_back(mk(4'b0010, word(2, 4'h9)));
    rqt = 4'b0100;
    tick();
    check("wd_gnt", gnt, 4'b0100);
    rqt = 4'b0000;
    set_port(2, 2'd3, 4'h0);
    tick();
    check("wd_wen", wen, 4'b0010);
    check("wd_fifo", fifo, word(2, 4'h9));
    tick();
    tick();
    check("wd_idle", busy, 0);
    check("wd_fifo_hold", fifo, word(2, 4'h9));

    drain(2);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
